// File: rtl/mips_mem_pkg.sv
// Shared types for the store sequencer: store kinds, FSM states and lane widths.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      ST_SW  = 2'b00,
      ST_SH  = 2'b01,
      ST_SB  = 2'b10,
      ST_RSV = 2'b11
   } store_type_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WT,
      S_WR,
      S_DN
   } rmw_state_t;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge of store data into the old memory word.
// Zero latency; no flow control. Halfword stores pick their half by byte_sel[1] alone.
module store_lane_merge
   import mips_mem_pkg::*;
(
   input  logic [WORD_W-1:0] old_word,
   input  logic [WORD_W-1:0] value,
   input  store_type_t       st_type,
   input  logic [1:0]        byte_sel,
   output logic [WORD_W-1:0] wdata
);

   always_comb begin
      wdata = old_word;
      case (st_type)
         ST_SW: wdata = value;
         ST_SH: begin
            if (byte_sel[1]) wdata[WORD_W-1:HALF_W] = value[HALF_W-1:0];
            else             wdata[HALF_W-1:0]      = value[HALF_W-1:0];
         end
         ST_SB:   wdata[{byte_sel, 3'b000} +: BYTE_W] = value[BYTE_W-1:0];
         default: wdata = old_word;
      endcase
   end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer: SW written directly, SH/SB via read-modify-write; done after 2 (SW) or 3+MEM_LAT cycles.
// Requests accepted only while ready (IDLE); STORE_ALIGN_CHECK_EN adds SW/SH misalignment faults.
module store_rmw_ctrl
   import mips_mem_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [1:0]        st_type,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] value,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [WORD_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

   rmw_state_t        state_q, state_d;
   store_type_t       st_q, st_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] value_q, value_d;
   logic [WORD_W-1:0] old_q, old_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              mem_wr_q, mem_wr_d;
   logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

   store_type_t       req_type;
   logic              misalign;
   logic              fault;
   logic              capture;
   logic [WORD_W-1:0] merge_old;
   logic [WORD_W-1:0] merged;

   assign req_type = store_type_t'(st_type);

`ifdef STORE_ALIGN_CHECK_EN
   assign misalign = ((req_type == ST_SW) && (addr[1:0] != 2'b00)) ||
                     ((req_type == ST_SH) && addr[0]);
`else
   assign misalign = 1'b0;
`endif

   assign fault = misalign || (req_type == ST_RSV);

   // Merge straight from mem_rdata on the capture edge so WR starts the next cycle.
   assign capture   = (state_q == S_WT) && (cnt_q == LAST);
   assign merge_old = capture ? mem_rdata : old_q;

   store_lane_merge u_merge (
      .old_word (merge_old),
      .value    (value_q),
      .st_type  (st_q),
      .byte_sel (addr_q[1:0]),
      .wdata    (merged)
   );

   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      addr_d      = addr_q;
      value_d     = value_q;
      old_d       = old_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: if (req) begin
            st_d    = req_type;
            addr_d  = addr;
            value_d = value;
            if (fault) begin
               state_d = S_DN;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               mem_addr_d = {addr[WORD_W-1:2], 2'b00};
               if (req_type == ST_SW) begin
                  state_d     = S_WR;
                  mem_wr_d    = 1'b1;
                  mem_wdata_d = value;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = S_WT;
            cnt_d   = '0;
         end
         S_WT: begin
            if (capture) begin
               old_d       = mem_rdata;
               mem_wdata_d = merged;
               mem_wr_d    = 1'b1;
               state_d     = S_WR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR: begin
            state_d = S_DN;
            done_d  = 1'b1;
         end
         S_DN:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         st_q        <= ST_SW;
         addr_q      <= '0;
         value_q     <= '0;
         old_q       <= '0;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         addr_q      <= addr_d;
         value_q     <= value_d;
         old_q       <= old_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench: store vectors on a MEM_LAT=1 instance, plus hold/reset/latency corner sequences.
module tb_store_rmw_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req1, req3;
   logic [1:0]  st_type;
   logic [31:0] addr, value;

   logic        rdy1, done1, err1, mwr1;
   logic [31:0] maddr1, mwdata1, mrdata1;
   logic        rdy3, done3, err3, mwr3;
   logic [31:0] maddr3, mwdata3, mrdata3;

   always #5 clk = ~clk;

   store_rmw_ctrl #(.MEM_LAT(1)) dut (
      .clk(clk), .reset(reset), .req(req1), .st_type(st_type), .addr(addr), .value(value),
      .ready(rdy1), .done(done1), .err(err1), .mem_addr(maddr1), .mem_wr(mwr1),
      .mem_wdata(mwdata1), .mem_rdata(mrdata1));

   store_rmw_ctrl #(.MEM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .req(req3), .st_type(st_type), .addr(addr), .value(value),
      .ready(rdy3), .done(done3), .err(err3), .mem_addr(maddr3), .mem_wr(mwr3),
      .mem_wdata(mwdata3), .mem_rdata(mrdata3));

   // Word memories with MEM_LAT-deep read pipelines and a bench preload port.
   logic [31:0] mem1 [256];
   logic [31:0] mem3 [256];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [3];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_dat;

   always @(posedge clk) begin
      if (mwr1)        mem1[maddr1[9:2]] <= mwdata1;
      else if (pre_we) mem1[pre_idx]     <= pre_dat;
      if (mwr3)        mem3[maddr3[9:2]] <= mwdata3;
      else if (pre_we) mem3[pre_idx]     <= pre_dat;
      pipe1    <= mem1[maddr1[9:2]];
      pipe3[0] <= mem3[maddr3[9:2]];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign mrdata1 = pipe1;
   assign mrdata3 = pipe3[2];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = a[9:2];
      pre_dat = d;
      @(negedge clk);
      pre_we  = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  st;
      logic [31:0] a;
      logic [31:0] v;
      logic [31:0] init;
      logic        flt;
      logic [31:0] exp_addr;
      logic [31:0] exp_wd;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] st, input logic [31:0] a, input logic [31:0] v,
                               input logic [31:0] init, input logic flt,
                               input logic [31:0] ea, input logic [31:0] ew);
      vec_t r;
      r.st = st; r.a = a; r.v = v; r.init = init; r.flt = flt; r.exp_addr = ea; r.exp_wd = ew;
      return r;
   endfunction

   vec_t vt [11];

   initial begin
      int nwr, wr_cyc, dcyc, nd;
      logic        e, rdy_after;
      logic [31:0] wd, wa;
      int exp_wr_cyc, exp_dcyc;

      vt[0] = mk(2'b00, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 32'h100, 32'hDEADBEEF);
      vt[1] = mk(2'b10, 32'h102, 32'h000000AA, 32'h11223344, 1'b0, 32'h100, 32'h11AA3344);
      vt[2] = mk(2'b01, 32'h202, 32'h0000BEEF, 32'hCAFE1234, 1'b0, 32'h200, 32'hBEEF1234);
      vt[3] = mk(2'b01, 32'h200, 32'h0000BEEF, 32'hCAFE1234, 1'b0, 32'h200, 32'hCAFEBEEF);
      vt[4] = mk(2'b10, 32'h103, 32'h00000055, 32'h11223344, 1'b0, 32'h100, 32'h55223344);
      vt[5] = mk(2'b10, 32'h100, 32'h00000077, 32'h11223344, 1'b0, 32'h100, 32'h11223377);
      vt[6] = mk(2'b10, 32'h101, 32'hFFFFFF99, 32'h11223344, 1'b0, 32'h100, 32'h11229944);
      vt[7] = mk(2'b11, 32'h300, 32'h00000001, 32'h0,        1'b1, 32'h0,   32'h0);
`ifdef STORE_ALIGN_CHECK_EN
      vt[8]  = mk(2'b01, 32'h101, 32'h0000BEEF, 32'hCAFE1234, 1'b1, 32'h0, 32'h0);
      vt[9]  = mk(2'b00, 32'h106, 32'h12345678, 32'h0,        1'b1, 32'h0, 32'h0);
      vt[10] = mk(2'b01, 32'h203, 32'h1234ABCD, 32'hCAFE1234, 1'b1, 32'h0, 32'h0);
`else
      vt[8]  = mk(2'b01, 32'h101, 32'h0000BEEF, 32'hCAFE1234, 1'b0, 32'h100, 32'hCAFEBEEF);
      vt[9]  = mk(2'b00, 32'h106, 32'h12345678, 32'h0,        1'b0, 32'h104, 32'h12345678);
      vt[10] = mk(2'b01, 32'h203, 32'h1234ABCD, 32'hCAFE1234, 1'b0, 32'h200, 32'hABCD1234);
`endif

      reset = 1'b1; req1 = 1'b0; req3 = 1'b0; st_type = 2'b00; addr = '0; value = '0;
      pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(rdy1), 32'd1);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_err", 32'(err1), 32'd0);
      chk("rst_mem_wr", 32'(mwr1), 32'd0);
      chk("rst_mem_addr", maddr1, 32'h0);
      chk("rst_mem_wdata", mwdata1, 32'h0);
      reset = 1'b0;
      preload(32'h0, 32'h0);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         preload(vt[i].a, vt[i].init);
         chk($sformatf("v%0d_ready_in", i), 32'(rdy1), 32'd1);
         st_type = vt[i].st; addr = vt[i].a; value = vt[i].v; req1 = 1'b1;
         @(posedge clk);
         #1 req1 = 1'b0;
         nwr = 0; wr_cyc = 0; dcyc = 0; e = 1'b0; wd = '0; wa = '0;
         for (int c = 1; c <= 20 && dcyc == 0; c++) begin
            @(negedge clk);
            if (mwr1) begin nwr++; wr_cyc = c; wd = mwdata1; wa = maddr1; end
            if (done1) begin dcyc = c; e = err1; end
         end
         @(negedge clk);
         rdy_after = rdy1;
         exp_wr_cyc = (vt[i].st == 2'b00) ? 1 : 3;
         exp_dcyc   = vt[i].flt ? 1 : ((vt[i].st == 2'b00) ? 2 : 4);
         chk($sformatf("v%0d_done_cycle", i), 32'(dcyc), 32'(exp_dcyc));
         chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].flt));
         chk($sformatf("v%0d_writes", i), 32'(nwr), vt[i].flt ? 32'd0 : 32'd1);
         chk($sformatf("v%0d_ready_after", i), 32'(rdy_after), 32'd1);
         if (!vt[i].flt) begin
            chk($sformatf("v%0d_wr_cycle", i), 32'(wr_cyc), 32'(exp_wr_cyc));
            chk($sformatf("v%0d_wr_addr", i), wa, vt[i].exp_addr);
            chk($sformatf("v%0d_wr_data", i), wd, vt[i].exp_wd);
         end
      end

      // req held high through an SB: exactly one store.
      preload(32'h102, 32'h11223344);
      st_type = 2'b10; addr = 32'h102; value = 32'h000000AA; req1 = 1'b1;
      @(posedge clk);
      nwr = 0; nd = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mwr1) nwr++;
         if (done1) nd++;
         if (c == 4) req1 = 1'b0;
      end
      chk("hold_writes", 32'(nwr), 32'd1);
      chk("hold_dones", 32'(nd), 32'd1);
      chk("hold_mem", mem1[8'h40], 32'h11AA3344);
      chk("hold_ready", 32'(rdy1), 32'd1);

      // Reset during WT: abort with no write and no done.
      preload(32'h104, 32'h55667788);
      st_type = 2'b10; addr = 32'h105; value = 32'h000000EE; req1 = 1'b1;
      @(posedge clk);
      #1 req1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rstwt_mem_wr", 32'(mwr1), 32'd0);
      chk("rstwt_ready", 32'(rdy1), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      nwr = 0; nd = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (mwr1) nwr++;
         if (done1) nd++;
      end
      chk("rstwt_writes", 32'(nwr), 32'd0);
      chk("rstwt_dones", 32'(nd), 32'd0);
      chk("rstwt_mem", mem1[8'h41], 32'h55667788);
      chk("rstwt_ready_after", 32'(rdy1), 32'd1);

      // Reset while a SW write is on the bus: mem_wr drops immediately.
      st_type = 2'b00; addr = 32'h108; value = 32'hA5A5A5A5; req1 = 1'b1;
      @(posedge clk);
      #1 req1 = 1'b0;
      @(negedge clk);
      chk("rstwr_mem_wr_before", 32'(mwr1), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstwr_mem_wr", 32'(mwr1), 32'd0);
      chk("rstwr_done", 32'(done1), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // MEM_LAT=3: capture on third WT cycle, write c5, done c6.
      preload(32'h102, 32'h11223344);
      st_type = 2'b10; addr = 32'h102; value = 32'h000000AA; req3 = 1'b1;
      @(posedge clk);
      #1 req3 = 1'b0;
      nwr = 0; wr_cyc = 0; dcyc = 0; e = 1'b0; wd = '0;
      for (int c = 1; c <= 20 && dcyc == 0; c++) begin
         @(negedge clk);
         if (mwr3) begin nwr++; wr_cyc = c; wd = mwdata3; end
         if (done3) begin dcyc = c; e = err3; end
      end
      chk("lat3_wr_cycle", 32'(wr_cyc), 32'd5);
      chk("lat3_wr_data", wd, 32'h11AA3344);
      chk("lat3_writes", 32'(nwr), 32'd1);
      chk("lat3_done_cycle", 32'(dcyc), 32'd6);
      chk("lat3_err", 32'(e), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
